i2s_sample_packer: RTL and testbench

I2S_SAMPLE_PACKER -- requirements
Module: i2s_sample_packer

---
 rtl/i2s_sample_packer_pkg.sv | 14 +
 rtl/i2s_sample_packer_if.sv | 22 ++
 rtl/i2s_abs_sat.sv | 28 ++
 rtl/i2s_sample_packer.sv | 153 +++++++++++++++
 tb/tb_i2s_sample_packer.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2s_sample_packer_pkg.sv
// Shared types and constants for the I2S sample packer.
package i2s_sample_packer_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HALF  = 1'b1
  } pk_state_e;

  localparam logic [31:0] SAT_MAG16  = 32'h0000_7FFF;
  localparam logic [31:0] SAT_MAG32  = 32'h7FFF_FFFF;
  localparam logic [15:0] MOST_NEG16 = 16'h8000;
  localparam logic [31:0] MOST_NEG32 = 32'h8000_0000;

endpackage

// File: rtl/i2s_sample_packer_if.sv
// Sample FIFO read port plus valid/ready output stream.
interface i2s_sample_packer_if #(parameter int DW = 32);

  logic          fifo_empty;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_rd;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;

  modport master (
    input  fifo_empty, fifo_rdata, m_ready,
    output fifo_rd, m_valid, m_data, m_last
  );

  modport slave (
    output fifo_empty, fifo_rdata, m_ready,
    input  fifo_rd, m_valid, m_data, m_last
  );

endinterface

// File: rtl/i2s_abs_sat.sv
// Saturating two's-complement magnitude of a 16-bit or 32-bit sample.
module i2s_abs_sat
  import i2s_sample_packer_pkg::*;
(
  input  logic [31:0] x,
  input  logic        sel16,
  output logic [31:0] mag
);

  logic [15:0] neg16;
  logic [31:0] neg32;

  always_comb begin
    neg16 = -x[15:0];
    neg32 = -x;
    mag   = '0;
    if (sel16) begin
      if (x[15:0] == MOST_NEG16) mag = SAT_MAG16;
      else if (x[15])            mag = {16'h0000, neg16};
      else                       mag = {16'h0000, x[15:0]};
    end else begin
      if (x == MOST_NEG32) mag = SAT_MAG32;
      else if (x[31])      mag = neg32;
      else                 mag = x;
    end
  end

endmodule

// File: rtl/i2s_sample_packer.sv
// Drains a sample FIFO into a framed output stream, optionally packing
// two 16-bit samples per word, and tracks per-frame peak magnitude.
//
//   state    | meaning
//   ST_EMPTY | no half-word held; pass-mode operation lives here
//   ST_HALF  | low 16-bit sample held, waiting for the upper one
module i2s_sample_packer
  import i2s_sample_packer_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                pack16,
  input  logic [7:0]          frame_len,
  i2s_sample_packer_if.master io,
  output logic [DW-1:0]       peak,
  output logic                peak_stb
);

  pk_state_e     state_q, state_d;
  logic          mode_q, mode_d;
  logic [15:0]   hold_q, hold_d;
  logic          m_valid_q, m_valid_d;
  logic          m_last_q, m_last_d;
  logic          peak_stb_q, peak_stb_d;
  logic [DW-1:0] m_data_q, m_data_d;
  logic [DW-1:0] run_q, run_d;
  logic [DW-1:0] peak_q, peak_d;
  logic [7:0]    wc_q, wc_d;

  logic          load_ok, xfer, avail, pop, load, hold_en;
  logic [DW-1:0] load_word, pop_mag, close_max;

  assign load_ok = ~m_valid_q | io.m_ready;
  assign xfer    = m_valid_q & io.m_ready;
  assign avail   = en & ~io.fifo_empty;

  i2s_abs_sat u_abs_sat (
    .x     (io.fifo_rdata),
    .sel16 (mode_q),
    .mag   (pop_mag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = ST_EMPTY;
    end else if (mode_q) begin
      if (state_q == ST_EMPTY && avail)               state_d = ST_HALF;
      else if (state_q == ST_HALF && avail && load_ok) state_d = ST_EMPTY;
    end
  end

  // The first half of a packed pair may pop even while the output is stalled.
  always_comb begin
    pop       = 1'b0;
    load      = 1'b0;
    hold_en   = 1'b0;
    load_word = io.fifo_rdata;
    if (en) begin
      if (!mode_q) begin
        pop  = avail & load_ok;
        load = pop;
      end else if (state_q == ST_EMPTY) begin
        pop     = avail;
        hold_en = pop;
      end else begin
        pop       = avail & load_ok;
        load      = pop;
        load_word = {io.fifo_rdata[15:0], hold_q};
      end
    end
  end

  assign io.fifo_rd = pop & rst_n;

  always_comb begin
    mode_d = mode_q;
    if (state_q == ST_EMPTY && !pop) mode_d = pack16;

    hold_d = hold_q;
    if (!en)          hold_d = '0;
    else if (hold_en) hold_d = io.fifo_rdata[15:0];

    wc_d = wc_q;
    if (xfer) wc_d = m_last_q ? 8'd0 : wc_q + 8'd1;

    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    if (load) begin
      m_valid_d = 1'b1;
      m_data_d  = load_word;
      m_last_d  = (wc_d == (frame_len - 8'd1));
    end else if (xfer) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end
    if (!en) wc_d = '0;

    // A pop on the frame-closing edge counts toward both frames.
    close_max  = (pop && (pop_mag > run_q)) ? pop_mag : run_q;
    peak_d     = peak_q;
    peak_stb_d = 1'b0;
    run_d      = run_q;
    if (xfer && m_last_q) begin
      peak_d     = close_max;
      peak_stb_d = 1'b1;
      run_d      = pop ? pop_mag : '0;
    end else if (pop) begin
      run_d = close_max;
    end
    if (!en) run_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= 1'b0;
      hold_q     <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_last_q   <= 1'b0;
      wc_q       <= '0;
      run_q      <= '0;
      peak_q     <= '0;
      peak_stb_q <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      hold_q     <= hold_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_last_q   <= m_last_d;
      wc_q       <= wc_d;
      run_q      <= run_d;
      peak_q     <= peak_d;
      peak_stb_q <= peak_stb_d;
    end
  end

  assign io.m_valid = m_valid_q;
  assign io.m_data  = m_data_q;
  assign io.m_last  = m_last_q;
  assign peak       = peak_q;
  assign peak_stb   = peak_stb_q;

endmodule

// File: tb/tb_i2s_sample_packer.sv
// Randomized bench for i2s_sample_packer with a FIFO model and a
// sample-stream reference model.
`timescale 1ns/1ps
module tb_i2s_sample_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        pack16 = 1'b0;
  logic [7:0]  frame_len = 8'd0;
  logic [31:0] peak;
  logic        peak_stb;

  int checks = 0;
  int failures = 0;

  i2s_sample_packer_if #(.DW(32)) bus ();

  i2s_sample_packer #(.DW(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .pack16    (pack16),
    .frame_len (frame_len),
    .io        (bus),
    .peak      (peak),
    .peak_stb  (peak_stb)
  );

  always #5 clk = ~clk;

  // FIFO model: stimulus writes mem/wr_ptr, pops advance rd_ptr
  logic [31:0] mem [0:4095];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  int   pops = 0;
  int   cyc = 0;
  int   pop_cyc [0:4095];
  logic flush = 1'b0;

  assign bus.fifo_empty = (rd_ptr == wr_ptr);
  assign bus.fifo_rdata = mem[rd_ptr[11:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (bus.fifo_rd) begin
      rd_ptr <= rd_ptr + 1;
      pops <= pops + 1;
      pop_cyc[pops[11:0]] <= cyc + 1;
    end
  end

  logic [31:0] out_data [$];
  logic        out_last [$];
  int          out_cyc  [$];
  logic [31:0] peak_log [$];

  always @(negedge clk) begin
    if (bus.m_valid && bus.m_ready) begin
      out_data.push_back(bus.m_data);
      out_last.push_back(bus.m_last);
      out_cyc.push_back(cyc + 1);
    end
    if (peak_stb) peak_log.push_back(peak);
  end

  function automatic logic [31:0] ref_mag(input logic [31:0] x, input bit is16);
    longint v;
    if (is16) begin
      v = longint'($signed(x[15:0]));
      if (v < 0) v = -v;
      if (v > 32767) v = 32767;
    end else begin
      v = longint'($signed(x));
      if (v < 0) v = -v;
      if (v > 64'sd2147483647) v = 64'sd2147483647;
    end
    return v[31:0];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    mem[wr_ptr[11:0]] = v;
    wr_ptr++;
  endtask

  task automatic idle();
    en = 1'b0;
    bus.m_ready = 1'b1;
    tick(3);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(1);
  endtask

  task automatic wait_words(input int n, input int base, input int budget, input string name);
    int t;
    t = 0;
    while ((out_data.size() - base < n) && t < budget) begin
      tick(1);
      t++;
    end
    checks++;
    if (out_data.size() - base < n) begin
      failures++;
      $display("FAIL %s timeout: got %0d words, need %0d", name, out_data.size() - base, n);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    push(32'h1234_5678);
    en = 1'b1;
    bus.m_ready = 1'b1;
    tick(2);
    checks += 6;
    if (bus.fifo_rd !== 1'b0) begin failures++; $display("FAIL reset_fifo_rd got %b need 0", bus.fifo_rd); end
    if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got %b need 0", bus.m_valid); end
    if (bus.m_data !== 32'h0) begin failures++; $display("FAIL reset_m_data got %h need 0", bus.m_data); end
    if (bus.m_last !== 1'b0) begin failures++; $display("FAIL reset_m_last got %b need 0", bus.m_last); end
    if (peak !== 32'h0) begin failures++; $display("FAIL reset_peak got %h need 0", peak); end
    if (peak_stb !== 1'b0) begin failures++; $display("FAIL reset_peak_stb got %b need 0", peak_stb); end
    en = 1'b0;
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_pass_basic();
    int base, pb;
    pack16 = 1'b0;
    frame_len = 8'd0;
    idle();
    base = out_data.size();
    pb = pops;
    push(32'h1111_1111);
    push(32'h2222_2222);
    en = 1'b1;
    wait_words(2, base, 20, "pass_words");
    if (out_data.size() - base >= 2) begin
      checks += 4;
      if (out_data[base] !== 32'h1111_1111) begin failures++; $display("FAIL pass_w0 got %h need 11111111", out_data[base]); end
      if (out_data[base+1] !== 32'h2222_2222) begin failures++; $display("FAIL pass_w1 got %h need 22222222", out_data[base+1]); end
      if (out_cyc[base+1] !== out_cyc[base] + 1) begin failures++; $display("FAIL pass_rate got %0d need %0d", out_cyc[base+1], out_cyc[base] + 1); end
      if (out_cyc[base] !== pop_cyc[pb] + 1) begin failures++; $display("FAIL pass_latency got %0d need %0d", out_cyc[base], pop_cyc[pb] + 1); end
    end
    en = 1'b0;
  endtask

  task automatic test_pack_basic();
    int base, pb;
    pack16 = 1'b1;
    idle();
    base = out_data.size();
    pb = pops;
    push(32'h0000_AAAA);
    push(32'h0000_BBBB);
    en = 1'b1;
    wait_words(1, base, 20, "pack_words");
    tick(2);
    checks += 2;
    if (pops - pb !== 2) begin failures++; $display("FAIL pack_pops got %0d need 2", pops - pb); end
    if (out_data.size() - base !== 1) begin failures++; $display("FAIL pack_count got %0d need 1", out_data.size() - base); end
    if (out_data.size() - base >= 1) begin
      checks += 2;
      if (out_data[base] !== 32'hBBBB_AAAA) begin failures++; $display("FAIL pack_w0 got %h need bbbbaaaa", out_data[base]); end
      if (out_cyc[base] !== pop_cyc[pb+1] + 1) begin failures++; $display("FAIL pack_latency got %0d need %0d", out_cyc[base], pop_cyc[pb+1] + 1); end
    end
    en = 1'b0;
  endtask

  task automatic test_backpressure();
    int base, p0, t;
    logic [31:0] s [8];
    logic [31:0] d0, w;
    pack16 = 1'b1;
    idle();
    for (int i = 0; i < 8; i++) s[i] = $urandom;
    bus.m_ready = 1'b0;
    base = out_data.size();
    for (int i = 0; i < 8; i++) push(s[i]);
    en = 1'b1;
    t = 0;
    while (!bus.m_valid && t < 50) begin tick(1); t++; end
    checks++;
    if (bus.m_valid !== 1'b1) begin failures++; $display("FAIL bp_valid timeout got %b need 1", bus.m_valid); end
    d0 = bus.m_data;
    p0 = pops;
    checks++;
    w = {s[1][15:0], s[0][15:0]};
    if (d0 !== w) begin failures++; $display("FAIL bp_first got %h need %h", d0, w); end
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checks++;
      if (bus.m_data !== d0 || bus.m_valid !== 1'b1) begin
        failures++;
        $display("FAIL bp_stable cycle %0d got %h/%b need %h/1", i, bus.m_data, bus.m_valid, d0);
      end
    end
    checks++;
    if (pops - p0 !== 1) begin failures++; $display("FAIL bp_extra_pops got %0d need 1", pops - p0); end
    bus.m_ready = 1'b1;
    wait_words(4, base, 40, "bp_words");
    for (int j = 0; j < 4 && base + j < out_data.size(); j++) begin
      w = {s[2*j+1][15:0], s[2*j][15:0]};
      checks++;
      if (out_data[base+j] !== w) begin failures++; $display("FAIL bp_order w%0d got %h need %h", j, out_data[base+j], w); end
    end
    en = 1'b0;
  endtask

  task automatic test_frames();
    int base, first_last, n_last;
    logic [31:0] s [$];
    pack16 = 1'b0;
    frame_len = 8'd3;
    idle();
    base = out_data.size();
    for (int i = 0; i < 7; i++) begin s.push_back($urandom); push(s[i]); end
    en = 1'b1;
    wait_words(7, base, 40, "frame3_words");
    for (int k = 0; k < 7 && base + k < out_data.size(); k++) begin
      checks += 2;
      if (out_data[base+k] !== s[k]) begin failures++; $display("FAIL frame3_data w%0d got %h need %h", k, out_data[base+k], s[k]); end
      if (out_last[base+k] !== ((k + 1) % 3 == 0)) begin failures++; $display("FAIL frame3_last w%0d got %b need %b", k, out_last[base+k], ((k + 1) % 3 == 0)); end
    end
    frame_len = 8'd0;
    idle();
    base = out_data.size();
    for (int i = 0; i < 257; i++) push(i);
    en = 1'b1;
    wait_words(257, base, 600, "frame256_words");
    first_last = -1;
    n_last = 0;
    for (int k = 0; base + k < out_data.size(); k++) begin
      if (out_last[base+k] === 1'b1) begin
        n_last++;
        if (first_last < 0) first_last = k;
      end
    end
    checks += 2;
    if (first_last !== 255) begin failures++; $display("FAIL frame256_pos got %0d need 255", first_last); end
    if (n_last !== 1) begin failures++; $display("FAIL frame256_count got %0d need 1", n_last); end
    en = 1'b0;
  endtask

  task automatic test_peak();
    int base, lbase;
    pack16 = 1'b0;
    frame_len = 8'd3;
    idle();
    base = out_data.size();
    lbase = peak_log.size();
    push(32'd5);
    push(32'h8000_0000);
    push(32'hFFFF_FFF9);
    en = 1'b1;
    wait_words(3, base, 20, "peak_fixed_words");
    tick(3);
    checks += 2;
    if (peak_log.size() - lbase !== 1) begin failures++; $display("FAIL peak_fixed_stb got %0d need 1", peak_log.size() - lbase); end
    if (peak !== 32'h7FFF_FFFF) begin failures++; $display("FAIL peak_fixed_value got %h need 7fffffff", peak); end
    en = 1'b0;

    for (int m = 0; m < 2; m++) begin
      int L, F, spw, N, lo, hi;
      logic [31:0] smp [$];
      logic [31:0] ep, v, mg;
      L = $urandom_range(1, 4);
      F = $urandom_range(2, 4);
      spw = m + 1;
      N = F * L * spw;
      smp.delete();
      for (int i = 0; i < N; i++) begin
        v = $urandom;
        if ($urandom_range(0, 5) == 0) v = (m == 1) ? {v[31:16], 16'h8000} : 32'h8000_0000;
        smp.push_back(v);
      end
      pack16 = (m == 1);
      frame_len = 8'(L);
      idle();
      for (int i = 0; i < N; i++) push(smp[i]);
      base = out_data.size();
      lbase = peak_log.size();
      en = 1'b1;
      wait_words(F * L, base, 400, "peak_rand_words");
      tick(3);
      checks++;
      if (peak_log.size() - lbase !== F) begin failures++; $display("FAIL peak_rand_count mode %0d got %0d need %0d", m, peak_log.size() - lbase, F); end
      for (int f = 0; f < F && lbase + f < peak_log.size(); f++) begin
        lo = f * L * spw;
        hi = (f + 1) * L * spw;
        if (hi > N - 1) hi = N - 1;
        ep = 32'h0;
        for (int i = lo; i <= hi; i++) begin
          mg = ref_mag(smp[i], m == 1);
          if (mg > ep) ep = mg;
        end
        checks++;
        if (peak_log[lbase+f] !== ep) begin failures++; $display("FAIL peak_rand mode %0d frame %0d got %h need %h", m, f, peak_log[lbase+f], ep); end
      end
      en = 1'b0;
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      bit md;
      int L, nw, ns, base, lbase, pushed, t;
      logic [31:0] smp [$];
      logic [31:0] w;
      md = ($urandom_range(0, 1) == 1);
      L = $urandom_range(1, 5);
      nw = $urandom_range(4, 20);
      ns = md ? 2 * nw : nw;
      smp.delete();
      for (int i = 0; i < ns; i++) smp.push_back($urandom);
      pack16 = md;
      frame_len = 8'(L);
      idle();
      base = out_data.size();
      lbase = peak_log.size();
      en = 1'b1;
      pushed = 0;
      t = 0;
      while ((out_data.size() - base < nw) && t < 2000) begin
        if (pushed < ns && $urandom_range(0, 3) != 0) begin push(smp[pushed]); pushed++; end
        bus.m_ready = ($urandom_range(0, 2) != 0);
        tick(1);
        t++;
      end
      checks++;
      if (out_data.size() - base < nw) begin failures++; $display("FAIL rand_timeout it %0d got %0d need %0d", it, out_data.size() - base, nw); end
      bus.m_ready = 1'b1;
      tick(3);
      for (int k = 0; k < nw && base + k < out_data.size(); k++) begin
        w = md ? {smp[2*k+1][15:0], smp[2*k][15:0]} : smp[k];
        checks += 2;
        if (out_data[base+k] !== w) begin failures++; $display("FAIL rand_data it %0d w%0d got %h need %h", it, k, out_data[base+k], w); end
        if (out_last[base+k] !== ((k + 1) % L == 0)) begin failures++; $display("FAIL rand_last it %0d w%0d got %b need %b", it, k, out_last[base+k], ((k + 1) % L == 0)); end
      end
      checks++;
      if (peak_log.size() - lbase !== nw / L) begin failures++; $display("FAIL rand_peak_stb it %0d got %0d need %0d", it, peak_log.size() - lbase, nw / L); end
      en = 1'b0;
    end
  endtask

  task automatic test_abort();
    int base, pb;
    pack16 = 1'b1;
    frame_len = 8'd0;
    idle();
    base = out_data.size();
    pb = pops;
    push(32'hDEAD_1111);
    en = 1'b1;
    tick(3);
    checks += 2;
    if (pops - pb !== 1) begin failures++; $display("FAIL abort_half_pops got %0d need 1", pops - pb); end
    if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL abort_half_valid got %b need 0", bus.m_valid); end
    en = 1'b0;
    tick(2);
    push(32'hBEEF_2222);
    push(32'hCAFE_3333);
    en = 1'b1;
    wait_words(1, base, 20, "abort_words");
    if (out_data.size() - base >= 1) begin
      checks++;
      if (out_data[base] !== 32'h3333_2222) begin failures++; $display("FAIL abort_fresh got %h need 33332222", out_data[base]); end
    end
    en = 1'b0;

    pack16 = 1'b0;
    idle();
    for (int i = 0; i < 20; i++) push($urandom | 32'h1);
    en = 1'b1;
    tick(5);
    #2 rst_n = 1'b0;
    #1;
    checks += 6;
    if (bus.fifo_rd !== 1'b0) begin failures++; $display("FAIL abort_rst_fifo_rd got %b need 0", bus.fifo_rd); end
    if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL abort_rst_m_valid got %b need 0", bus.m_valid); end
    if (bus.m_data !== 32'h0) begin failures++; $display("FAIL abort_rst_m_data got %h need 0", bus.m_data); end
    if (bus.m_last !== 1'b0) begin failures++; $display("FAIL abort_rst_m_last got %b need 0", bus.m_last); end
    if (peak !== 32'h0) begin failures++; $display("FAIL abort_rst_peak got %h need 0", peak); end
    if (peak_stb !== 1'b0) begin failures++; $display("FAIL abort_rst_peak_stb got %b need 0", peak_stb); end
    tick(1);
    en = 1'b0;
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    rst_n = 1'b1;
    tick(1);
    base = out_data.size();
    push(32'hABCD_0001);
    en = 1'b1;
    wait_words(1, base, 20, "resume_words");
    if (out_data.size() - base >= 1) begin
      checks++;
      if (out_data[base] !== 32'hABCD_0001) begin failures++; $display("FAIL resume_data got %h need abcd0001", out_data[base]); end
    end
    en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    bus.m_ready = 1'b0;
    test_reset();
    test_pass_basic();
    test_pack_basic();
    test_backpressure();
    test_frames();
    test_peak();
    test_random();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
